// File: rtl/joojump_counter_8bit_src_pkg.sv
// Shared definitions for the joojump 8-bit counter: register map,
// CONTROL bit positions and the counter FSM state encoding.
package joojump_counter_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned COUNT_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_LOAD     = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 2'd3;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_DOWN   = 1;
  localparam int unsigned CTRL_WRAP   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/joojump_counter_8bit_src_if.sv
// Avalon-MM control bus of the counter.
//   address   : register select
//   write     : write strobe, zero wait states
//   writedata : write data
//   read      : read strobe
//   readdata  : registered read data, one-cycle latency
interface joojump_counter_8bit_src_if;
  import joojump_counter_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;

  modport master (output address, output write, output writedata, output read, input readdata);
  modport slave  (input address, input write, input writedata, input read, output readdata);
endinterface

// File: rtl/joojump_counter_8bit_src_prescaler.sv
// Programmable clock divider: tick_c pulses once every prescale+1 clocks
// while clear is low; clear holds the divider at zero and masks the tick.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : force divider to 0 (not running / LOAD or PRESCALE write)
//   prescale   : reload value
//   tick_c     : combinational one-cycle tick
module joojump_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] div_cnt;

  assign tick_c = ~clear & (div_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/joojump_counter_8bit_src.sv
// Free-running / one-shot 8-bit counter with programmable prescaler and an
// Avalon-MM control slave. count_out feeds the game processor's PIO in_port.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : Avalon-MM slave (CONTROL, PRESCALE, LOAD, STATUS)
//   count_out  : registered live count
//   tc_pulse   : one-cycle pulse on a terminal-count tick
//   irq        : level interrupt, present only with JOOJUMP_COUNTER_IRQ_EN
// Optional feature macro: JOOJUMP_COUNTER_IRQ_EN.
module joojump_counter_8bit_src
  import joojump_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W     = 16,
  parameter int unsigned RESET_PRESCALE = 0,
  parameter int unsigned RESET_RUN      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  joojump_counter_8bit_src_if.slave bus,
  output logic [COUNT_W-1:0]        count_out,
  output logic                      tc_pulse
`ifdef JOOJUMP_COUNTER_IRQ_EN
  ,
  output logic                      irq
`endif
);

  state_t                state;
  logic                  ctrl_run;
  logic                  ctrl_down;
  logic                  ctrl_wrap;
  logic                  irq_en_bit;
  logic [PRESCALE_W-1:0] prescale;
  logic [COUNT_W-1:0]    load_val;
  logic                  tc_sticky;

  logic wr_ctrl, wr_prescale, wr_load, wr_status;
  logic pre_clear, tick_c, tc_hit_c;
  logic [COUNT_W-1:0] terminal_c, count_next_c;
  logic [DATA_W-1:0]  rd_mux_c;
  logic               unused_wdata;

`ifdef JOOJUMP_COUNTER_IRQ_EN
  logic ctrl_irq_en;
  assign irq_en_bit = ctrl_irq_en;
`else
  assign irq_en_bit = 1'b0;
`endif

  assign unused_wdata = ^bus.writedata;

  // Bus write decode
  assign wr_ctrl     = bus.write && (bus.address == ADDR_CONTROL);
  assign wr_prescale = bus.write && (bus.address == ADDR_PRESCALE);
  assign wr_load     = bus.write && (bus.address == ADDR_LOAD);
  assign wr_status   = bus.write && (bus.address == ADDR_STATUS);

  assign pre_clear = (state != RUNNING) || wr_load || wr_prescale;

  joojump_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (pre_clear),
    .prescale (prescale),
    .tick_c   (tick_c)
  );

  // Terminal is judged on the count before the step; a LOAD cancels the tick.
  assign terminal_c   = ctrl_down ? 8'h00 : 8'hFF;
  assign count_next_c = ctrl_down ? (count_out - 8'd1) : (count_out + 8'd1);
  assign tc_hit_c     = tick_c && !wr_load && (count_out == terminal_c);

  // Read mux samples the registers as they stand in the read cycle
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      ADDR_CONTROL:  rd_mux_c = {28'd0, irq_en_bit, ctrl_wrap, ctrl_down, ctrl_run};
      ADDR_PRESCALE: rd_mux_c = 32'(prescale);
      ADDR_LOAD:     rd_mux_c = {24'd0, load_val};
      ADDR_STATUS:   rd_mux_c = {14'd0, state, count_out, 7'd0, tc_sticky};
      default:       rd_mux_c = '0;
    endcase
  end

  // Counter core, FSM and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (RESET_RUN != 0) ? RUNNING : STOPPED;
      ctrl_run  <= (RESET_RUN != 0);
      ctrl_down <= 1'b0;
      ctrl_wrap <= (RESET_RUN != 0);
      prescale  <= PRESCALE_W'(RESET_PRESCALE);
      load_val  <= '0;
      tc_sticky <= 1'b0;
      count_out <= '0;
      tc_pulse  <= 1'b0;
      bus.readdata <= '0;
`ifdef JOOJUMP_COUNTER_IRQ_EN
      ctrl_irq_en <= 1'b0;
      irq         <= 1'b0;
`endif
    end else begin
      tc_pulse  <= tc_hit_c;
      // Set beats a coincident write-1-to-clear
      tc_sticky <= tc_hit_c || (tc_sticky && !(wr_status && bus.writedata[0]));

      if (bus.read) begin
        bus.readdata <= rd_mux_c;
      end

      if (wr_load) begin
        count_out <= bus.writedata[COUNT_W-1:0];
        load_val  <= bus.writedata[COUNT_W-1:0];
        if (state == EXPIRED) begin
          state    <= RUNNING;
          ctrl_run <= 1'b1;
        end
      end else if (tick_c) begin
        if (tc_hit_c && !ctrl_wrap) begin
          state    <= EXPIRED;
          ctrl_run <= 1'b0;
        end else begin
          count_out <= count_next_c;
        end
      end

      if (wr_prescale) begin
        prescale <= bus.writedata[PRESCALE_W-1:0];
      end

      // A CONTROL write decides the state over anything the tick did
      if (wr_ctrl) begin
        ctrl_run  <= bus.writedata[CTRL_RUN];
        ctrl_down <= bus.writedata[CTRL_DOWN];
        ctrl_wrap <= bus.writedata[CTRL_WRAP];
        state     <= bus.writedata[CTRL_RUN] ? RUNNING : STOPPED;
`ifdef JOOJUMP_COUNTER_IRQ_EN
        ctrl_irq_en <= bus.writedata[CTRL_IRQ_EN];
`endif
      end

`ifdef JOOJUMP_COUNTER_IRQ_EN
      irq <= tc_sticky && ctrl_irq_en;
`endif
    end
  end

endmodule

// File: tb/tb_joojump_counter_8bit_src.sv
module tb_joojump_counter_8bit_src;
  import joojump_counter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] count_out;
  logic tc_pulse;
`ifdef JOOJUMP_COUNTER_IRQ_EN
  logic irq;
`endif

  joojump_counter_8bit_src_if bus ();

  joojump_counter_8bit_src dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .count_out (count_out),
    .tc_pulse  (tc_pulse)
`ifdef JOOJUMP_COUNTER_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model (state: 0 stopped, 1 running, 2 expired)
  int m_state, m_count, m_pre, m_prescale, m_load;
  bit m_run, m_down, m_wrap, m_irqen, m_tc, m_tcpulse, m_irq;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_pre = 0; m_prescale = 0; m_load = 0;
    m_run = 0; m_down = 0; m_wrap = 0; m_irqen = 0;
    m_tc = 0; m_tcpulse = 0; m_irq = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_irqen, m_wrap, m_down, m_run};
      2'd1:    return 32'(m_prescale);
      2'd2:    return 32'(m_load);
      default: return 32'((m_state << 16) | (m_count << 8) | int'(m_tc));
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_step();
    bit ld, pw, cw, sw, tick, hit, nirq;
    int n_pre;
    if (reset) begin
      model_reset();
      return;
    end
    ld = bus.write && bus.address == 2'd2;
    pw = bus.write && bus.address == 2'd1;
    cw = bus.write && bus.address == 2'd0;
    sw = bus.write && bus.address == 2'd3;
    if (bus.read) m_rdata = reg_val(bus.address);
    nirq = m_tc && m_irqen;
    tick = 0;
    n_pre = 0;
    if (m_state == 1 && !ld && !pw) begin
      if (m_pre == m_prescale) tick = 1;
      else n_pre = m_pre + 1;
    end
    hit = tick && !ld && (m_count == (m_down ? 0 : 255));
    m_tcpulse = hit;
    m_tc = hit || (m_tc && !(sw && bus.writedata[0]));
    if (ld) begin
      m_count = int'(bus.writedata[7:0]);
      m_load = m_count;
      if (m_state == 2) begin m_state = 1; m_run = 1; end
    end else if (tick) begin
      if (hit && !m_wrap) begin m_state = 2; m_run = 0; end
      else m_count = (m_count + (m_down ? 255 : 1)) % 256;
    end
    if (pw) m_prescale = int'(bus.writedata[15:0]);
    if (cw) begin
      m_run = bus.writedata[0];
      m_down = bus.writedata[1];
      m_wrap = bus.writedata[2];
`ifdef JOOJUMP_COUNTER_IRQ_EN
      m_irqen = bus.writedata[3];
`endif
      m_state = bus.writedata[0] ? 1 : 0;
    end
    m_pre = n_pre;
    m_irq = nirq;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("count_out", 32'(count_out), 32'(m_count));
    chk("tc_pulse", 32'(tc_pulse), 32'(m_tcpulse));
    chk("readdata", bus.readdata, m_rdata);
`ifdef JOOJUMP_COUNTER_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    cycle();
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    bus.address = a; bus.read = 1'b1;
    cycle();
    bus.read = 1'b0;
  endtask

  initial begin
    int ncyc, r;
    logic [31:0] d;
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    model_reset();

    // Reset and idle hold
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_tc", 32'(tc_pulse), 32'd0);
    repeat (100) cycle();
    chk("idle_hold", 32'(count_out), 32'd0);

    // Prescale 3: one tick every 4 clocks
    bus_write(ADDR_PRESCALE, 32'd3);
    bus_write(ADDR_CONTROL, 32'h5);
    repeat (40) cycle();
    chk("presc3_40clk", 32'(count_out), 32'd10);

    // Up wrap through 0xFF
    bus_write(ADDR_CONTROL, 32'h0);
    bus_write(ADDR_LOAD, 32'hFE);
    bus_write(ADDR_PRESCALE, 32'd0);
    bus_write(ADDR_CONTROL, 32'h5);
    cycle();
    chk("wrap_ff", 32'(count_out), 32'hFF);
    cycle();
    chk("wrap_00", 32'(count_out), 32'h00);
    chk("wrap_tc", 32'(tc_pulse), 32'd1);
    bus_write(ADDR_CONTROL, 32'h0);
    chk("wrap_single_tc", 32'(tc_pulse), 32'd0);
    bus_read(ADDR_STATUS);
    chk("wrap_status", bus.readdata, 32'h0000_0101);
    bus_write(ADDR_STATUS, 32'h1);

    // Down one-shot to EXPIRED
    bus_write(ADDR_LOAD, 32'h02);
    bus_write(ADDR_CONTROL, 32'h3);
    cycle();
    chk("dn_01", 32'(count_out), 32'h01);
    cycle();
    chk("dn_00", 32'(count_out), 32'h00);
    cycle();
    chk("dn_tc", 32'(tc_pulse), 32'd1);
    cycle(); cycle();
    chk("dn_hold", 32'(count_out), 32'h00);
    bus_read(ADDR_CONTROL);
    chk("dn_control", bus.readdata, 32'h2);
    bus_read(ADDR_STATUS);
    chk("dn_status", bus.readdata, 32'h0002_0001);

    // LOAD coincident with a tick, W1C coincident with tc
    bus_write(ADDR_CONTROL, 32'h5);
    cycle(); cycle();
    bus_write(ADDR_LOAD, 32'h40);
    chk("ld_tick_val", 32'(count_out), 32'h40);
    cycle();
    chk("ld_tick_next", 32'(count_out), 32'h41);
    bus_write(ADDR_STATUS, 32'h1);
    bus_write(ADDR_LOAD, 32'hFF);
    bus_write(ADDR_STATUS, 32'h1);
    chk("w1c_tc_pulse", 32'(tc_pulse), 32'd1);
    bus_read(ADDR_STATUS);
    chk("w1c_set_wins", 32'(bus.readdata[0]), 32'd1);

    // Reset on the edge of a terminal tick suppresses tc_pulse
    bus_write(ADDR_LOAD, 32'hFF);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_tc", 32'(tc_pulse), 32'd0);
    chk("rst_mid_count", 32'(count_out), 32'd0);
    bus_read(ADDR_CONTROL);
    chk("rst_mid_ctrl", bus.readdata, 32'd0);

`ifdef JOOJUMP_COUNTER_IRQ_EN
    bus_write(ADDR_LOAD, 32'hFF);
    bus_write(ADDR_CONTROL, 32'hD);
    cycle();
    chk("irq_tc", 32'(tc_pulse), 32'd1);
    chk("irq_not_yet", 32'(irq), 32'd0);
    cycle();
    chk("irq_rise", 32'(irq), 32'd1);
    bus_write(ADDR_STATUS, 32'h1);
    chk("irq_w1c_edge", 32'(irq), 32'd1);
    cycle();
    chk("irq_clear", 32'(irq), 32'd0);
    bus_write(ADDR_CONTROL, 32'h0);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      bus_write(ADDR_CONTROL, 32'h0);
      bus_write(ADDR_PRESCALE, 32'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 4));
      d = (r == 0) ? 32'hFF : (r == 1) ? 32'h00 : (r == 2) ? 32'hFE : (r == 3) ? 32'h01 : 32'($urandom_range(0, 255));
      bus_write(ADDR_LOAD, d);
      bus_write(ADDR_CONTROL, {28'd0, 3'($urandom_range(0, 7)), 1'b1});
      ncyc = int'($urandom_range(5, 40));
      for (int c = 0; c < ncyc; c++) begin
        r = int'($urandom_range(0, 19));
        case (r)
          0: bus_write(ADDR_LOAD, 32'($urandom_range(0, 255)));
          1: bus_write(ADDR_STATUS, 32'($urandom_range(0, 1)));
          2, 3: bus_read(2'($urandom_range(0, 3)));
          4: bus_write(ADDR_CONTROL, 32'($urandom_range(0, 15)));
          5: bus_write(ADDR_PRESCALE, 32'($urandom_range(0, 3)));
          default: cycle();
        endcase
      end
      bus_read(ADDR_STATUS);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
